// File: rtl/video_pkg.sv
// Shared video types for the analog video receive and transmit paths.
//
// Contents:
//   t_parallel_video - pad/encoder-side parallel video bundle
//   t_video_timing   - raster timing description (pixels / lines per region)
//   VT_1024x768      - standard 1024x768 raster
//   t_tx_state       - transmitter sequencing states
//   h_total/v_total  - total pixels per line / lines per frame of a timing

package video_pkg;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] t_cnt;

    typedef struct packed {
        logic        clock;
        logic        hsync_n;
        logic        vsync_n;
        logic        de;
        logic [23:0] data;
        logic        locked;
    } t_parallel_video;

    typedef struct packed {
        t_cnt h_active;
        t_cnt h_front;
        t_cnt h_sync;
        t_cnt h_back;
        t_cnt v_active;
        t_cnt v_front;
        t_cnt v_sync;
        t_cnt v_back;
    } t_video_timing;

    localparam t_video_timing VT_1024x768 = '{
        h_active: t_cnt'(1024),
        h_front:  t_cnt'(24),
        h_sync:   t_cnt'(136),
        h_back:   t_cnt'(160),
        v_active: t_cnt'(768),
        v_front:  t_cnt'(3),
        v_sync:   t_cnt'(6),
        v_back:   t_cnt'(29)
    };

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StRun
    } t_tx_state;

    function automatic t_cnt h_total(input t_video_timing t);
        return t.h_active + t.h_front + t.h_sync + t.h_back;
    endfunction

    function automatic t_cnt v_total(input t_video_timing t);
        return t.v_active + t.v_front + t.v_sync + t.v_back;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters plus region decode.
//
// Ports:
//   clock       in   pixel clock
//   reset_n     in   synchronous active-low reset
//   enable      in   1 = counters advance one pixel per clock
//   clear       in   1 = counters forced to 0 (overrides enable)
//   active      out  inside the active picture area
//   hsync       out  inside the horizontal sync pulse (active high)
//   vsync       out  on a vertical sync line (active high, whole lines)
//   frame_start out  first pixel of the frame (h=0, v=0)
//
// All decode outputs are combinational from the current counter values.

module video_timing_gen
    import video_pkg::*;
#(
    parameter t_video_timing TIMING = VT_1024x768
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_start
);

    localparam t_cnt H_TOTAL  = h_total(TIMING);
    localparam t_cnt V_TOTAL  = v_total(TIMING);
    localparam t_cnt HS_START = TIMING.h_active + TIMING.h_front;
    localparam t_cnt HS_END   = HS_START + TIMING.h_sync;
    localparam t_cnt VS_START = TIMING.v_active + TIMING.v_front;
    localparam t_cnt VS_END   = VS_START + TIMING.v_sync;

    t_cnt h_cnt_q, h_cnt_d;
    t_cnt v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clear) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (enable) begin
            if (h_cnt_q == H_TOTAL - t_cnt'(1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_TOTAL - t_cnt'(1)) ? '0 : v_cnt_q + t_cnt'(1);
            end else begin
                h_cnt_d = h_cnt_q + t_cnt'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        active      = (h_cnt_q < TIMING.h_active) && (v_cnt_q < TIMING.v_active);
        hsync       = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vsync       = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

endmodule

// File: rtl/analog_transmitter.sv
// Parallel video transmitter toward an external video encoder/DAC.
//
// Runs a programmable raster and fills its active area from a valid/ready
// pixel stream framed by a start-of-frame marker. Errors are reported
// through sticky flags.
//
// Ports:
//   clock      in   pixel clock (only clock)
//   reset_n    in   synchronous active-low reset
//   enable     in   1 = run raster, 0 = idle with inactive outputs
//   pix_data   in   {R,G,B} pixel, 8 bits each
//   pix_sof    in   first pixel of a frame
//   pix_valid  in   beat valid
//   pix_ready  out  beat consumed when pix_valid & pix_ready
//   tx_video   out  registered parallel video bundle (clock passed through)
//   underflow  out  sticky: an active pixel had no valid beat
//   misalign   out  sticky: sof did not line up with the frame start
//   err_clr    in   clears both sticky flags (a same-cycle set wins)

module analog_transmitter
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FRONT  = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BACK   = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FRONT  = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BACK   = 29
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [23:0]     pix_data,
    input  logic            pix_sof,
    input  logic            pix_valid,
    output logic            pix_ready,
    output t_parallel_video tx_video,
    output logic            underflow,
    output logic            misalign,
    input  logic            err_clr
);

    localparam t_video_timing TIMING = '{
        h_active: t_cnt'(H_ACTIVE),
        h_front:  t_cnt'(H_FRONT),
        h_sync:   t_cnt'(H_SYNC),
        h_back:   t_cnt'(H_BACK),
        v_active: t_cnt'(V_ACTIVE),
        v_front:  t_cnt'(V_FRONT),
        v_sync:   t_cnt'(V_SYNC),
        v_back:   t_cnt'(V_BACK)
    };

    t_tx_state   state_q, state_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        de_q, de_d;
    logic [23:0] data_q, data_d;
    logic        underflow_q, underflow_d;
    logic        misalign_q, misalign_d;
    logic        underflow_set;
    logic        misalign_set;
    logic        sof_error;

    logic active;
    logic hsync;
    logic vsync;
    logic frame_start;

    // Counters sit at 0 through IDLE (including the cycle enable is first
    // seen) and start advancing once the state register reaches SEEK.
    video_timing_gen #(
        .TIMING (TIMING)
    ) u_timing (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (state_q != StIdle),
        .clear       (!enable),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // sof is expected exactly on the frame's first pixel and nowhere else.
    assign sof_error = frame_start ? !pix_sof : pix_sof;

    // Ready never looks at pix_valid, so there is no valid->ready path.
    always_comb begin
        pix_ready = 1'b0;
        unique case (state_q)
            StSeek:  pix_ready = !pix_sof || frame_start;
            StRun:   pix_ready = active && !sof_error;
            default: pix_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hsync_n_d     = 1'b1;
        vsync_n_d     = 1'b1;
        de_d          = 1'b0;
        data_d        = '0;
        underflow_set = 1'b0;
        misalign_set  = 1'b0;

        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSeek;
                end
                StSeek: begin
                    hsync_n_d = !hsync;
                    vsync_n_d = !vsync;
                    de_d      = active;
                    // The aligned sof beat is both consumed and shown.
                    if (pix_valid && pix_sof && frame_start) begin
                        data_d  = pix_data;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    hsync_n_d = !hsync;
                    vsync_n_d = !vsync;
                    de_d      = active;
                    if (active) begin
                        if (!pix_valid) begin
                            underflow_set = 1'b1;
                            state_d       = StSeek;
                        end else if (sof_error) begin
                            misalign_set = 1'b1;
                            state_d      = StSeek;
                        end else begin
                            data_d = pix_data;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Disabling abandons the frame and returns the flags to idle too.
        if (!enable) begin
            underflow_d = 1'b0;
            misalign_d  = 1'b0;
        end else begin
            underflow_d = underflow_set || (underflow_q && !err_clr);
            misalign_d  = misalign_set || (misalign_q && !err_clr);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            de_q        <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
            de_q        <= de_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        tx_video.clock   = clock;
        tx_video.hsync_n = hsync_n_q;
        tx_video.vsync_n = vsync_n_q;
        tx_video.de      = de_q;
        tx_video.data    = data_q;
        tx_video.locked  = (state_q == StRun);
    end

    assign underflow = underflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_analog_transmitter.sv
// Scoreboarded bench for analog_transmitter on a tiny 8x6 raster
// (H 4/1/2/1, V 3/1/1/1): 4 active pixels on lines 0-2, 48 clocks/frame.

module tb_analog_transmitter;
    import video_pkg::*;

    localparam int CLK_P = 10;

    typedef struct {
        logic        valid;
        logic        sof;
        logic [23:0] data;
    } beat_t;

    logic            clock;
    logic            reset_n;
    logic            enable;
    logic [23:0]     pix_data;
    logic            pix_sof;
    logic            pix_valid;
    logic            pix_ready;
    t_parallel_video tx_video;
    logic            underflow;
    logic            misalign;
    logic            err_clr;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          base     = 0;
    bit          mon_en   = 0;
    beat_t       src_q[$];
    logic [23:0] exp_q[$];

    analog_transmitter #(
        .H_ACTIVE (4),
        .H_FRONT  (1),
        .H_SYNC   (2),
        .H_BACK   (1),
        .V_ACTIVE (3),
        .V_FRONT  (1),
        .V_SYNC   (1),
        .V_BACK   (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .tx_video  (tx_video),
        .underflow (underflow),
        .misalign  (misalign),
        .err_clr   (err_clr)
    );

    initial clock = 1'b0;
    always #(CLK_P / 2) clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus side: a beat goes to the source; a beat that will be shown
    // goes to the expected-pixel queue as well.
    task automatic add_beat(input logic v, input logic s, input logic [23:0] d, input bit shown);
        beat_t b;
        b.valid = v;
        b.sof   = s;
        b.data  = d;
        src_q.push_back(b);
        if (shown) exp_q.push_back(d);
    endtask

    task automatic present();
        if (src_q.size() > 0) begin
            pix_valid = src_q[0].valid;
            pix_sof   = src_q[0].sof;
            pix_data  = src_q[0].data;
        end else begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            pix_data  = '0;
        end
    endtask

    // Waits until the registered outputs show raster position n
    // (n = -1 is the cycle right after enable is sampled).
    task automatic wait_out(input int n);
        while (cyc - base - 2 < n) @(negedge clock);
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, tx_video.hsync_n, tx_video.vsync_n, tx_video.de, tx_video.data,
                tx_video.locked, pix_ready, underflow, misalign};
    endfunction

    localparam logic [31:0] IDLE_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 4'b0000};

    // Source: a valid beat leaves on handshake; a bubble lasts one cycle.
    initial begin : source
        bit take;
        forever begin
            @(negedge clock);
            take = (src_q.size() > 0) && (!src_q[0].valid || pix_ready);
            @(posedge clock);
            #1;
            if (take) void'(src_q.pop_front());
            present();
        end
    end

    // Monitor: every locked active pixel pops the scoreboard; anything else
    // must carry zero data.
    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (tx_video.de && tx_video.locked) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pixel_extra actual=%0h required=none", tx_video.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(tx_video.data), 32'(e));
                    end
                end else begin
                    check("blank_data", 32'(tx_video.data), 32'h0);
                end
            end
        end
    end

    initial begin : watchdog
        #(CLK_P * 5000);
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int de_cnt;
        int hs_lo;
        int vs_lo;
        int k;
        bit hs_seen;

        reset_n = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;

        // frame 0: aligned from the first pixel
        add_beat(1'b1, 1'b1, 24'h000001, 1'b1);
        for (int i = 2; i <= 12; i++) add_beat(1'b1, 1'b0, 24'(i), 1'b1);
        // frame 1: 5 pixels, bubble on pixel 6, then 5 stray beats to flush
        add_beat(1'b1, 1'b1, 24'h000101, 1'b1);
        for (int i = 2; i <= 5; i++) add_beat(1'b1, 1'b0, 24'h000100 + 24'(i), 1'b1);
        add_beat(1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 1; i <= 5; i++) add_beat(1'b1, 1'b0, 24'h0002F0 + 24'(i), 1'b0);
        // frame 2: full recovery frame
        add_beat(1'b1, 1'b1, 24'h000201, 1'b1);
        for (int i = 2; i <= 12; i++) add_beat(1'b1, 1'b0, 24'h000200 + 24'(i), 1'b1);
        // frame 3: second pixel carries a stray sof; that beat opens frame 4
        add_beat(1'b1, 1'b1, 24'h000301, 1'b1);
        add_beat(1'b1, 1'b1, 24'h000401, 1'b1);
        for (int i = 2; i <= 12; i++) add_beat(1'b1, 1'b0, 24'h000400 + 24'(i), 1'b1);
        // frame 5: abandoned by disable after two pixels
        add_beat(1'b1, 1'b1, 24'h000501, 1'b1);
        add_beat(1'b1, 1'b0, 24'h000502, 1'b1);
        for (int i = 3; i <= 12; i++) add_beat(1'b1, 1'b0, 24'h000500 + 24'(i), 1'b0);
        present();

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // idle with a valid beat waiting: nothing moves
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_outputs", out_vec(), IDLE_VEC);
        end

        @(posedge clock);
        #1;
        enable = 1'b1;
        base   = cyc;

        wait_out(-1);
        check("locked_before_sof", 32'(tx_video.locked), 32'd0);

        de_cnt = 0;
        hs_lo  = 0;
        vs_lo  = 0;
        for (int n = 0; n < 48; n++) begin
            wait_out(n);
            if (n == 0) check("locked_after_sof", 32'(tx_video.locked), 32'd1);
            check("de", 32'(tx_video.de), ((n % 8) < 4 && (n / 8) < 3) ? 32'd1 : 32'd0);
            check("hsync_n", 32'(tx_video.hsync_n),
                  ((n % 8) == 5 || (n % 8) == 6) ? 32'd0 : 32'd1);
            check("vsync_n", 32'(tx_video.vsync_n), ((n / 8) == 4) ? 32'd0 : 32'd1);
            de_cnt += int'(tx_video.de);
            hs_lo  += int'(!tx_video.hsync_n);
            vs_lo  += int'(!tx_video.vsync_n);
        end
        check("de_per_frame", 32'(de_cnt), 32'd12);
        check("hsync_low_per_frame", 32'(hs_lo), 32'd12);
        check("vsync_low_per_frame", 32'(vs_lo), 32'd8);

        // underflow on pixel 6 of frame 1
        wait_out(56);
        check("underflow_before_drop", 32'(underflow), 32'd0);
        wait_out(57);
        check("underflow_set", 32'(underflow), 32'd1);
        check("locked_after_drop", 32'(tx_video.locked), 32'd0);
        check("de_on_dropped_pixel", 32'(tx_video.de), 32'd1);
        wait_out(90);
        check("sof_held_ready", 32'(pix_ready), 32'd0);
        check("misalign_after_flush", 32'(misalign), 32'd0);
        wait_out(96);
        check("relock_frame2", 32'(tx_video.locked), 32'd1);
        wait_out(130);
        check("underflow_sticky", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        wait_out(131);
        err_clr = 1'b0;
        check("underflow_cleared", 32'(underflow), 32'd0);

        // stray sof on pixel 2 of frame 3
        wait_out(145);
        check("misalign_set", 32'(misalign), 32'd1);
        check("locked_after_misalign", 32'(tx_video.locked), 32'd0);
        check("underflow_on_misalign", 32'(underflow), 32'd0);
        wait_out(190);
        check("held_sof_ready", 32'(pix_ready), 32'd0);
        wait_out(192);
        check("relock_frame4", 32'(tx_video.locked), 32'd1);
        wait_out(200);
        err_clr = 1'b1;
        wait_out(201);
        err_clr = 1'b0;
        check("misalign_cleared", 32'(misalign), 32'd0);

        // disable mid-active-line in frame 5
        wait_out(241);
        check("locked_before_disable", 32'(tx_video.locked), 32'd1);
        enable = 1'b0;
        @(negedge clock);
        check("disable_idle", out_vec(), IDLE_VEC);

        repeat (3) @(posedge clock);
        #1;
        enable = 1'b1;
        @(posedge clock);
        k       = 0;
        hs_seen = 1'b0;
        while (k < 20 && !hs_seen) begin
            @(posedge clock);
            k++;
            @(negedge clock);
            if (!tx_video.hsync_n) hs_seen = 1'b1;
        end
        check("hsync_after_reenable", 32'(k), 32'd6);

        repeat (60) @(negedge clock);
        check("final_underflow", 32'(underflow), 32'd0);
        check("final_misalign", 32'(misalign), 32'd0);
        check("final_locked", 32'(tx_video.locked), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
